dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer for the 64×16 data memory. It shares the memory's single combinational port between two requesters, for example the CPU datapath (port 0) and a loader/debug engine (port 1). The block registers each granted access, drives the memory write enable as a clean single-cycle pulse with stable address and data, and returns read data with a one-cycle acknowledge.

## Interface
Parameters:
- AW, 6, memory address width
- DW, 16, memory data width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- r0_req  in  1  port 0 request; held until r0_ack
- r0_we  in  1  port 0 write (1) / read (0); stable while r0_req
- r0_addr  in  AW  port 0 address; stable while r0_req
- r0_wdata  in  DW  port 0 write data; stable while r0_req
- r0_ack  out  1  port 0 completion pulse, one cycle
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack: same as port 0, for port 1
- rdata  out  DW  read data of the completed access; valid while either ack is high
- mem_wr  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory combinational read data

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE
  - No request: stay in IDLE.
  - Any req high: pick a winner, register its we/addr/wdata into mem_wr/mem_addr/mem_wdata, record the winner index, and go to ACCESS.
- ACCESS (exactly one cycle)
  - Memory port is driven from registers.
  - At the closing edge: capture mem_rdata into rdata if the access is a read, clear mem_wr, set the winner's ack, and go to DONE.
- DONE (exactly one cycle)
  - Winner's ack is high. Clear ack and go to IDLE.
  - Requests are not sampled in DONE, so a requester dropping req after seeing ack is never re-granted.
- Arbitration is 2-way round-robin with a 1-bit pointer `last`.
  - On a simultaneous request, the port that is not `last` wins.
  - A single request wins unconditionally.
  - `last` updates to the winner on every grant.
- On a write, rdata holds its previous value; it is updated only on reads.
- mem_wr is high only in ACCESS and only for writes. mem_addr and mem_wdata do not change while mem_wr is high.
- The two acks are never high together.
- If a requester drops req mid-transaction, the transaction still completes and ack still pulses. The requester ignores it.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, `last` = 1 (port 0 wins the first tie)
  - mem_wr = 0, mem_addr = 0, mem_wdata = 0, rdata = 0, r0_ack = r1_ack = 0
- Reset mid-ACCESS aborts the access: mem_wr falls without waiting for a clock edge, and no ack is issued.
- Latency: req sampled high at edge E0, memory driven E0→E1, ack and rdata high E1→E2, IDLE from E2.
- The earliest next grant is at E3, so throughput is one access per 3 cycles.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package dmem_pkg holds:
  - AW/DW defaults
  - state encoding constants: IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2
  - port index constants PORT0/PORT1
- The natural sub-module is rr_arb2, a combinational 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: grant valid and winner index.
  - The top level owns the FSM, the `last` register, and all datapath registers.
- The memory stays external. The arbiter connects to its wr/addr/data_in/data_out pins.

## Test plan
- **Single write then read, port 0:** write 0xBEEF to addr 5, then read addr 5 → mem_wr high exactly one cycle with mem_addr = 5; the read ack has rdata = 0xBEEF.
- **Tie after reset:** both ports request at the same edge (r0 writes 0x1111 to addr 3, r1 reads addr 3) → port 0 is acked first. Port 1 is acked 3 cycles later with rdata = 0x1111.
- **Fairness:** both ports hold req continuously for 6 transactions → acks alternate 0,1,0,1,0,1. The two acks never overlap.
- **Write hold:** write 0x00FF to addr 63 → rdata keeps its prior value. While mem_wr is high, mem_addr stays 63 and mem_wdata stays 0x00FF.
- **Reset mid-ACCESS:** assert rst while a port 1 write to addr 10 is in ACCESS → mem_wr falls immediately, no ack is issued, and all outputs return to 0. The next tie goes to port 0.
- **Request held through DONE:** r0_req stays high one cycle past its ack → exactly one ack is produced for that request; the next grant occurs no earlier than E3.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: default widths,
// FSM state encoding and requester port indices.
package dmem_pkg;

    localparam int DMEM_AW = 6;
    localparam int DMEM_DW = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the external
// 64x16 data memory. The arbiter uses the slave view; whoever drives the
// requests and models the memory uses the master view.
interface dmem_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 16
);
    logic          r0_req;
    logic          r0_we;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_ack;

    logic          r1_req;
    logic          r1_we;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_ack;

    logic [DW-1:0] rdata;

    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  mem_rdata,
        output r0_ack, r1_ack, rdata,
        output mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output mem_rdata,
        input  r0_ack, r1_ack, rdata,
        input  mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker. A lone request always wins;
// on a tie the port that did not win last time is chosen.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // Select the winning port from the request pair and the last winner.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = PORT0;
        case (req)
            2'b01: begin
                gnt_valid = 1'b1;
                gnt_idx   = PORT0;
            end
            2'b10: begin
                gnt_valid = 1'b1;
                gnt_idx   = PORT1;
            end
            2'b11: begin
                gnt_valid = 1'b1;
                if (last == PORT0) begin
                    gnt_idx = PORT1;
                end else begin
                    gnt_idx = PORT0;
                end
            end
            default: begin
                gnt_valid = 1'b0;
                gnt_idx   = PORT0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the 64x16 data memory.
// Each grant runs IDLE -> ACCESS -> DONE: the memory port is driven from
// registers for one cycle, then the winner gets a one-cycle ack with the
// read data. Requests are ignored in DONE so a requester that drops req
// after its ack is never granted twice.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    state_t        state_r;
    state_t        state_next_s;
    logic          last_r;
    logic          win_r;
    logic          mem_wr_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;
    logic [DW-1:0] rdata_r;
    logic          r0_ack_r;
    logic          r1_ack_r;

    logic          gnt_valid_s;
    logic          gnt_idx_s;
    logic          grant_s;
    logic          finish_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;

    rr_arb2 u_rr_arb2 (
        .req       ({bus.r1_req, bus.r0_req}),
        .last      (last_r),
        .gnt_valid (gnt_valid_s),
        .gnt_idx   (gnt_idx_s)
    );

    // State register; reset returns to IDLE immediately, aborting any access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic plus the grant and completion strobes for the datapath.
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (gnt_valid_s) begin
                    state_next_s = ACCESS;
                    grant_s      = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: begin
                state_next_s = DONE;
                finish_s     = 1'b1;
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Route the winning requester's command towards the memory registers.
    always_comb begin
        sel_we_s    = bus.r0_we;
        sel_addr_s  = bus.r0_addr;
        sel_wdata_s = bus.r0_wdata;
        if (gnt_idx_s == PORT1) begin
            sel_we_s    = bus.r1_we;
            sel_addr_s  = bus.r1_addr;
            sel_wdata_s = bus.r1_wdata;
        end else begin
            sel_we_s    = bus.r0_we;
            sel_addr_s  = bus.r0_addr;
            sel_wdata_s = bus.r0_wdata;
        end
    end

    // Datapath: load the granted command, then close the access with an ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r      <= PORT1;
            win_r       <= PORT0;
            mem_wr_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
            rdata_r     <= {DW{1'b0}};
            r0_ack_r    <= 1'b0;
            r1_ack_r    <= 1'b0;
        end else begin
            r0_ack_r <= 1'b0;
            r1_ack_r <= 1'b0;
            if (grant_s) begin
                mem_wr_r    <= sel_we_s;
                mem_addr_r  <= sel_addr_s;
                mem_wdata_r <= sel_wdata_s;
                win_r       <= gnt_idx_s;
                last_r      <= gnt_idx_s;
            end else if (finish_s) begin
                // Address and data stay put; only the write strobe drops.
                mem_wr_r <= 1'b0;
                if (!mem_wr_r) begin
                    rdata_r <= bus.mem_rdata;
                end else begin
                    rdata_r <= rdata_r;
                end
                r0_ack_r <= (win_r == PORT0);
                r1_ack_r <= (win_r == PORT1);
            end else begin
                mem_wr_r <= mem_wr_r;
            end
        end
    end

    assign bus.mem_wr    = mem_wr_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.rdata     = rdata_r;
    assign bus.r0_ack    = r0_ack_r;
    assign bus.r1_ack    = r1_ack_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a table of single-port transactions plus
// hand-written sequences for ties, fairness, DONE-phase holding and reset
// in the middle of an access. The 64x16 memory is modelled here.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int AW = 6;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model: unwritten words read back as 0xA000 | addr.
    bit [DW-1:0] mem   [0:63];
    bit          mem_v [0:63];
    always @(posedge clk) begin
        if (bus.mem_wr) begin
            mem[bus.mem_addr]   <= bus.mem_wdata;
            mem_v[bus.mem_addr] <= 1'b1;
        end
    end
    assign bus.mem_rdata = mem_v[bus.mem_addr] ? mem[bus.mem_addr]
                                               : {4'hA, 6'h00, bus.mem_addr};

    // Monitor of write strobes and acks, sampled mid-cycle.
    int          wr_cycles = 0;
    int          ack0_cnt  = 0;
    int          ack1_cnt  = 0;
    int          overlap   = 0;
    logic [5:0]  last_wr_addr = 6'd0;
    logic [15:0] last_wr_data = 16'd0;
    always @(negedge clk) begin
        if (bus.mem_wr) begin
            wr_cycles    <= wr_cycles + 1;
            last_wr_addr <= bus.mem_addr;
            last_wr_data <= bus.mem_wdata;
        end
        if (bus.r0_ack) ack0_cnt <= ack0_cnt + 1;
        if (bus.r1_ack) ack1_cnt <= ack1_cnt + 1;
        if (bus.r0_ack && bus.r1_ack) overlap <= overlap + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic port, input logic req, input logic we,
                             input logic [5:0] addr, input logic [15:0] wdata);
        if (port == PORT1) begin
            bus.r1_req = req; bus.r1_we = we; bus.r1_addr = addr; bus.r1_wdata = wdata;
        end else begin
            bus.r0_req = req; bus.r0_we = we; bus.r0_addr = addr; bus.r0_wdata = wdata;
        end
    endtask

    // One transaction on one port, starting from IDLE at posedge+1.
    task automatic txn(input logic port, input logic we, input logic [5:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp_rd, input string tag);
        int          w0;
        int          lat;
        bit          got;
        logic [15:0] rd;
        logic        oth;
        w0  = wr_cycles;
        got = 1'b0; lat = 0; rd = 16'd0; oth = 1'b0;
        drive_req(port, 1'b1, we, addr, wdata);
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (port ? bus.r1_ack : bus.r0_ack) begin
                got = 1'b1;
                lat = i;
                rd  = bus.rdata;
                oth = port ? bus.r0_ack : bus.r1_ack;
            end
        end
        chk({tag, "_acked"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, lat, 32'd3);
        chk({tag, "_other_ack"}, 32'(oth), 32'd0);
        chk({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
        @(posedge clk); #1;
        drive_req(port, 1'b0, 1'b0, 6'd0, 16'd0);
        chk({tag, "_wr_cycles"}, wr_cycles - w0, we ? 32'd1 : 32'd0);
        if (we) begin
            chk({tag, "_wr_addr"}, 32'(last_wr_addr), 32'(addr));
            chk({tag, "_wr_data"}, 32'(last_wr_data), 32'(wdata));
        end
    endtask

    int          ack_port_q[$];
    int          ack_cyc_q[$];
    logic [15:0] ack_rd_q[$];

    // Record acks from both ports; optionally drop each req after its ack.
    task automatic collect(input int n_acks, input bit drop_on_ack, input int budget, input string tag);
        bit drop0;
        bit drop1;
        ack_port_q.delete(); ack_cyc_q.delete(); ack_rd_q.delete();
        for (int i = 0; i < budget && ack_port_q.size() < n_acks; i++) begin
            @(negedge clk);
            drop0 = 1'b0; drop1 = 1'b0;
            if (bus.r0_ack) begin
                ack_port_q.push_back(0); ack_cyc_q.push_back(i); ack_rd_q.push_back(bus.rdata);
                drop0 = drop_on_ack;
            end
            if (bus.r1_ack) begin
                ack_port_q.push_back(1); ack_cyc_q.push_back(i); ack_rd_q.push_back(bus.rdata);
                drop1 = drop_on_ack;
            end
            @(posedge clk); #1;
            if (drop0) bus.r0_req = 1'b0;
            if (drop1) bus.r1_req = 1'b0;
        end
        chk({tag, "_ack_count"}, ack_port_q.size(), n_acks);
    endtask

    function automatic int q_port(input int k);
        return (k < ack_port_q.size()) ? ack_port_q[k] : -1;
    endfunction
    function automatic int q_cyc(input int k);
        return (k < ack_cyc_q.size()) ? ack_cyc_q[k] : -100;
    endfunction
    function automatic logic [15:0] q_rd(input int k);
        return (k < ack_rd_q.size()) ? ack_rd_q[k] : 16'hDEAD;
    endfunction

    typedef struct packed {
        logic        port;
        logic        we;
        logic [5:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int a0;
        int a1;
        int c0;
        int c1;
        bit got;

        vecs[0] = '{PORT0, 1'b1, 6'd5,  16'hBEEF, 16'hA005};
        vecs[1] = '{PORT0, 1'b0, 6'd5,  16'h0000, 16'hBEEF};
        vecs[2] = '{PORT0, 1'b1, 6'd63, 16'h00FF, 16'hBEEF};
        vecs[3] = '{PORT0, 1'b0, 6'd63, 16'h0000, 16'h00FF};
        vecs[4] = '{PORT1, 1'b0, 6'd7,  16'h0000, 16'hA007};
        vecs[5] = '{PORT1, 1'b1, 6'd0,  16'h1234, 16'hA007};
        vecs[6] = '{PORT0, 1'b0, 6'd0,  16'h0000, 16'h1234};
        vecs[7] = '{PORT1, 1'b0, 6'd5,  16'h0000, 16'hBEEF};

        rst = 1'b1;
        drive_req(PORT0, 1'b0, 1'b0, 6'd0, 16'd0);
        drive_req(PORT1, 1'b0, 1'b0, 6'd0, 16'd0);
        #3;
        chk("reset_mem_wr",    32'(bus.mem_wr),    32'd0);
        chk("reset_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("reset_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("reset_rdata",     32'(bus.rdata),     32'd0);
        chk("reset_acks",      32'({bus.r1_ack, bus.r0_ack}), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Tie after reset: port 0 writes, port 1 reads the same word.
        drive_req(PORT0, 1'b1, 1'b1, 6'd3, 16'h1111);
        drive_req(PORT1, 1'b1, 1'b0, 6'd3, 16'h0000);
        collect(2, 1'b1, 20, "tie");
        chk("tie_first_port",  q_port(0), 32'd0);
        chk("tie_first_rdata", 32'(q_rd(0)), 32'h0000);
        chk("tie_second_port", q_port(1), 32'd1);
        chk("tie_spacing",     q_cyc(1) - q_cyc(0), 32'd3);
        chk("tie_second_rdata", 32'(q_rd(1)), 32'h1111);
        @(posedge clk); #1;

        // Fairness: both hold req for six transactions.
        drive_req(PORT0, 1'b1, 1'b0, 6'd3, 16'h0000);
        drive_req(PORT1, 1'b1, 1'b0, 6'd5, 16'h0000);
        collect(6, 1'b0, 40, "fair");
        drive_req(PORT0, 1'b0, 1'b0, 6'd0, 16'd0);
        drive_req(PORT1, 1'b0, 1'b0, 6'd0, 16'd0);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("fair_port%0d", k), q_port(k), k % 2);
            chk($sformatf("fair_rdata%0d", k), 32'(q_rd(k)), (k % 2 == 0) ? 32'h1111 : 32'hA005);
            if (k > 0) chk($sformatf("fair_spacing%0d", k), q_cyc(k) - q_cyc(k - 1), 32'd3);
        end
        repeat (2) @(posedge clk);
        #1;

        // Table-driven single-port transactions.
        for (int v = 0; v < 8; v++) begin
            txn(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rd,
                $sformatf("vec%0d", v));
        end

        // Request held into DONE: one ack only, next grant at E3.
        a0 = ack0_cnt;
        drive_req(PORT0, 1'b1, 1'b0, 6'd63, 16'h0000);
        got = 1'b0; c0 = 0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (bus.r0_ack) begin got = 1'b1; c0 = i; end
        end
        chk("hold_r0_acked", 32'(got), 32'd1);
        chk("hold_r0_rdata", 32'(bus.rdata), 32'h00FF);
        drive_req(PORT1, 1'b1, 1'b0, 6'd0, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        bus.r0_req = 1'b0;
        got = 1'b0; c1 = 0;
        for (int i = 2; i <= 12 && !got; i++) begin
            @(negedge clk);
            if (bus.r1_ack) begin got = 1'b1; c1 = i; end
        end
        chk("hold_r1_acked", 32'(got), 32'd1);
        chk("hold_next_grant_gap", c1, 32'd3);
        chk("hold_r1_rdata", 32'(bus.rdata), 32'h1234);
        @(posedge clk); #1;
        bus.r1_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("hold_r0_ack_count", ack0_cnt - a0, 32'd1);
        if (c0 == 0) chk("hold_r0_latency", c0, 32'd3);

        // Reset while a port 1 write is in ACCESS.
        a1 = ack1_cnt;
        drive_req(PORT1, 1'b1, 1'b1, 6'd10, 16'h5A5A);
        @(posedge clk); #2;
        chk("midrst_pre_mem_wr",   32'(bus.mem_wr),   32'd1);
        chk("midrst_pre_mem_addr", 32'(bus.mem_addr), 32'd10);
        rst = 1'b1;
        #1;
        chk("midrst_mem_wr",    32'(bus.mem_wr),    32'd0);
        chk("midrst_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("midrst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("midrst_rdata",     32'(bus.rdata),     32'd0);
        chk("midrst_acks",      32'({bus.r1_ack, bus.r0_ack}), 32'd0);
        drive_req(PORT1, 1'b0, 1'b0, 6'd0, 16'd0);
        @(negedge clk); rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_ack", ack1_cnt - a1, 32'd0);
        chk("midrst_not_written", 32'(mem_v[10]), 32'd0);

        // Tie after the mid-access reset goes to port 0 again.
        drive_req(PORT0, 1'b1, 1'b0, 6'd10, 16'h0000);
        drive_req(PORT1, 1'b1, 1'b0, 6'd5,  16'h0000);
        collect(2, 1'b1, 20, "tie2");
        chk("tie2_first_port",   q_port(0), 32'd0);
        chk("tie2_first_rdata",  32'(q_rd(0)), 32'hA00A);
        chk("tie2_second_port",  q_port(1), 32'd1);
        chk("tie2_second_rdata", 32'(q_rd(1)), 32'hBEEF);
        repeat (3) @(posedge clk);
        #1;

        chk("ack_overlap", overlap, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
